// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO with power-of-two depth, programmable almost
// thresholds, show-ahead or registered read port, synchronous flush and sticky error flags.
module param_sync_fifo #(
  parameter int DATA_WIDTH = 91,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 2,
  parameter int SHOWAHEAD  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  read,
  input  logic                  flush,
  input  logic                  clearErrors,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  outValid,
  output logic                  fifoFull,
  output logic                  fifoEmpty,
  output logic                  almostFull,
  output logic                  almostEmpty,
  output logic [ADDR_WIDTH:0]   usedWords,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_W    = (ADDR_WIDTH + 1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_W    = (ADDR_WIDTH + 1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wrPtr;
  logic [ADDR_WIDTH-1:0] rdPtr;
  logic                  wrAcc;
  logic                  rdAcc;

  // Handshake: a write is taken on any cycle with valid=1 and fifoFull=0, a read on any
  // cycle with read=1 and fifoEmpty=0; requests against the opposite flag are dropped
  // and recorded in overflow/underflow. Both decisions use registered flags only.
  assign wrAcc = valid & ~fifoFull;
  assign rdAcc = read & ~fifoEmpty;

  assign fifoFull    = (usedWords == DEPTH_W);
  assign fifoEmpty   = (usedWords == '0);
  assign almostFull  = (usedWords >= AF_W);
  assign almostEmpty = (usedWords <= AE_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      usedWords <= '0;
    end else if (flush) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      usedWords <= '0;
    end else begin
      if (wrAcc) wrPtr <= wrPtr + 1'b1;
      if (rdAcc) rdPtr <= rdPtr + 1'b1;
      if (wrAcc && !rdAcc)      usedWords <= usedWords + 1'b1;
      else if (rdAcc && !wrAcc) usedWords <= usedWords - 1'b1;
    end
  end

  // A new error in the same cycle wins over clearErrors; flush leaves the flags alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (valid && fifoFull)  overflow <= 1'b1;
      else if (clearErrors)   overflow <= 1'b0;
      if (read && fifoEmpty)  underflow <= 1'b1;
      else if (clearErrors)   underflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wrAcc && !flush) mem[wrPtr] <= data;
  end

  if (SHOWAHEAD != 0) begin : g_showAhead
    assign out      = mem[rdPtr];
    assign outValid = ~fifoEmpty;
  end else begin : g_regRead
    logic [DATA_WIDTH-1:0] outReg;
    logic                  outValidReg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        outReg      <= '0;
        outValidReg <= 1'b0;
      end else if (flush) begin
        outValidReg <= 1'b0;
      end else if (rdAcc) begin
        outReg      <= mem[rdPtr];
        outValidReg <= 1'b1;
      end else begin
        outValidReg <= 1'b0;
      end
    end

    assign out      = outReg;
    assign outValid = outValidReg;
  end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: a show-ahead and a registered-read instance share one
// stimulus stream and are checked against a queue-based reference model.
module tb_param_sync_fifo;

  localparam int DW = 91;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int AF = 12;
  localparam int AE = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid = 1'b0;
  logic [DW-1:0] data = '0;
  logic          read = 1'b0;
  logic          flush = 1'b0;
  logic          clearErrors = 1'b0;

  logic [DW-1:0] outA, outB;
  logic          outValidA, outValidB;
  logic          fullA, fullB, emptyA, emptyB, afA, afB, aeA, aeB;
  logic [AW:0]   usedA, usedB;
  logic          ovfA, ovfB, unfA, unfB;

  param_sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(AF), .AE_THRESH(AE),
                    .SHOWAHEAD(1)) dut_a (
    .clk(clk), .rst(rst), .valid(valid), .data(data), .read(read), .flush(flush),
    .clearErrors(clearErrors), .out(outA), .outValid(outValidA), .fifoFull(fullA),
    .fifoEmpty(emptyA), .almostFull(afA), .almostEmpty(aeA), .usedWords(usedA),
    .overflow(ovfA), .underflow(unfA)
  );

  param_sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(AF), .AE_THRESH(AE),
                    .SHOWAHEAD(0)) dut_b (
    .clk(clk), .rst(rst), .valid(valid), .data(data), .read(read), .flush(flush),
    .clearErrors(clearErrors), .out(outB), .outValid(outValidB), .fifoFull(fullB),
    .fifoEmpty(emptyB), .almostFull(afB), .almostEmpty(aeB), .usedWords(usedB),
    .overflow(ovfB), .underflow(unfB)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model and scoreboard ----------------
  logic [DW-1:0] mq[$];      // model FIFO contents, head at index 0
  logic          mOvf = 1'b0;
  logic          mUnf = 1'b0;
  logic [DW-1:0] exp_a[$];   // words the show-ahead port must present on accepted reads
  logic [DW-1:0] exp_b[$];   // words the registered port must pulse out

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    return DW'({$urandom(), $urandom(), $urandom()});
  endfunction

  task automatic check_status();
    int n;
    n = mq.size();
    chk("usedA", 128'(usedA), 128'(n));
    chk("usedB", 128'(usedB), 128'(n));
    chk("fullA", 128'(fullA), 128'(n == DEPTH));
    chk("fullB", 128'(fullB), 128'(n == DEPTH));
    chk("emptyA", 128'(emptyA), 128'(n == 0));
    chk("emptyB", 128'(emptyB), 128'(n == 0));
    chk("almostFullA", 128'(afA), 128'(n >= AF));
    chk("almostFullB", 128'(afB), 128'(n >= AF));
    chk("almostEmptyA", 128'(aeA), 128'(n <= AE));
    chk("almostEmptyB", 128'(aeB), 128'(n <= AE));
    chk("overflowA", 128'(ovfA), 128'(mOvf));
    chk("overflowB", 128'(ovfB), 128'(mOvf));
    chk("underflowA", 128'(unfA), 128'(mUnf));
    chk("underflowB", 128'(unfB), 128'(mUnf));
  endtask

  // Monitor: pops the expected word whenever a port presents one.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (read && outValidA && !flush) begin
          if (exp_a.size() == 0) chk("outA_unexpected", 128'(outA), 128'(0) - 1);
          else chk("outA", 128'(outA), 128'(exp_a.pop_front()));
        end
        if (outValidB) begin
          if (exp_b.size() == 0) chk("outB_unexpected", 128'(outB), 128'(0) - 1);
          else chk("outB", 128'(outB), 128'(exp_b.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One clock cycle of stimulus; entered and left at posedge+1.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r,
                      input logic f = 1'b0, input logic c = 1'b0);
    logic isFull, isEmpty, wa, ra;
    valid = v; data = d; read = r; flush = f; clearErrors = c;
    isFull  = (mq.size() == DEPTH);
    isEmpty = (mq.size() == 0);
    wa = v && !isFull;
    ra = r && !isEmpty;
    if (ra && !f) begin
      exp_a.push_back(mq[0]);
      exp_b.push_back(mq[0]);
    end
    @(negedge clk);
    check_status();
    @(posedge clk);
    if (v && isFull) mOvf = 1'b1;
    else if (c)      mOvf = 1'b0;
    if (r && isEmpty) mUnf = 1'b1;
    else if (c)       mUnf = 1'b0;
    if (f) mq.delete();
    else begin
      if (ra) void'(mq.pop_front());
      if (wa) mq.push_back(d);
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0);
  endtask

  task automatic reset_check();
    chk("rst_outValidA", 128'(outValidA), 128'(0));
    chk("rst_outValidB", 128'(outValidB), 128'(0));
    chk("rst_outB", 128'(outB), 128'(0));
    chk("rst_usedA", 128'(usedA), 128'(0));
    chk("rst_usedB", 128'(usedB), 128'(0));
    chk("rst_emptyA", 128'(emptyA), 128'(1));
    chk("rst_almostEmptyA", 128'(aeA), 128'(1));
    chk("rst_fullA", 128'(fullA), 128'(0));
    chk("rst_almostFullA", 128'(afA), 128'(0));
    chk("rst_overflowA", 128'(ovfA), 128'(0));
    chk("rst_underflowA", 128'(unfA), 128'(0));
    chk("rst_overflowB", 128'(ovfB), 128'(0));
    chk("rst_underflowB", 128'(unfB), 128'(0));
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear without a clock edge.
  task automatic mid_reset();
    valid = 1'b0; read = 1'b0; flush = 1'b0; clearErrors = 1'b0;
    rst = 1'b1;
    #1;
    reset_check();
    mq.delete();
    exp_a.delete();
    exp_b.delete();
    mOvf = 1'b0;
    mUnf = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #12;
    reset_check();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fill with 1..16, then one write too many.
    for (int i = 1; i <= DEPTH; i++) step(1'b1, DW'(i), 1'b0);
    step(1'b1, DW'(32'h99), 1'b0);
    idle();

    // Drain in order, then one read too many.
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    idle();

    // Simultaneous write+read on an empty FIFO: write wins, read flagged.
    step(1'b1, DW'(32'hAB), 1'b1);
    step(1'b0, '0, 1'b1);
    idle();

    // Steady occupancy of 5 with wrap-around.
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, rnd(), 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, rnd(), 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
    idle();

    // Flush with a concurrent write; the underflow flag set first must survive it.
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, rnd(), 1'b0);
    step(1'b1, rnd(), 1'b0, 1'b1);
    idle();
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle();

    // Registered-read pulses for 0x5, 0x6.
    step(1'b1, DW'(5), 1'b0);
    step(1'b1, DW'(6), 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    idle();
    idle();

    // Reset while a registered-read pulse is on the output.
    step(1'b1, DW'(7), 1'b0);
    step(1'b1, DW'(8), 1'b0);
    step(1'b0, '0, 1'b1);
    mid_reset();
    idle();

    // Random traffic: write-heavy, read-heavy, then balanced.
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 150; i++) begin
        logic v, r, f, c;
        v = (ph == 0) ? ($urandom_range(0, 3) != 0) : (ph == 1) ? ($urandom_range(0, 3) == 0)
                                                               : ($urandom_range(0, 1) == 1);
        r = (ph == 0) ? ($urandom_range(0, 3) == 0) : (ph == 1) ? ($urandom_range(0, 3) != 0)
                                                               : ($urandom_range(0, 1) == 1);
        f = ($urandom_range(0, 40) == 0);
        c = ($urandom_range(0, 15) == 0);
        step(v, rnd(), r, f, c);
      end
    end
    for (int i = 0; i < 3; i++) idle();

    chk("exp_a_drained", 128'(exp_a.size()), 128'(0));
    chk("exp_b_drained", 128'(exp_b.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
